// File: rtl/operand_loader_p.sv
// rtl/operand_loader_p.sv - chunk-serial operand loader for the ECC datapath front end
//
// Purpose: assembles N_OPS operands of OP_W bits from BEATS accepted beats of
// CHUNK_W bits per lane (LSB chunk first), then pulses o_load_done for one cycle.
// Optional macro OPERAND_LOADER_UNLOAD_EN adds a chunk serializer for result unload.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start, i_abort  arm a new load / cancel the load in progress
//   i_valid, i_chunk  beat handshake input; lane j at [j*CHUNK_W +: CHUNK_W]
//   o_ready           beat accepted when i_valid && o_ready
//   o_busy            high in LOAD or DONE
//   o_load_done       one-cycle pulse, all operands valid
//   o_ops             lane j operand at [j*OP_W +: OP_W]
//   o_beat_cnt        beats accepted in the current load
//   (OPERAND_LOADER_UNLOAD_EN) i_unload_start, i_unload_word, i_unload_ready,
//                     o_unload_chunk, o_unload_valid, o_unload_last
module operand_loader_p #(
  parameter int OP_W    = 32,
  parameter int CHUNK_W = 4,
  parameter int N_OPS   = 5,
  localparam int BEATS  = OP_W / CHUNK_W,
  localparam int CNT_W  = $clog2(BEATS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_valid,
  input  logic [N_OPS*CHUNK_W-1:0] i_chunk,
  output logic                     o_ready,
  output logic                     o_busy,
  output logic                     o_load_done,
  output logic [N_OPS*OP_W-1:0]    o_ops,
  output logic [CNT_W-1:0]         o_beat_cnt
`ifdef OPERAND_LOADER_UNLOAD_EN
  ,
  input  logic                     i_unload_start,
  input  logic [OP_W-1:0]          i_unload_word,
  output logic [CHUNK_W-1:0]       o_unload_chunk,
  output logic                     o_unload_valid,
  output logic                     o_unload_last,
  input  logic                     i_unload_ready
`endif
);

  if (OP_W % CHUNK_W != 0) begin : g_bad_width
    $error("operand_loader_p: OP_W must be a multiple of CHUNK_W");
  end

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;

  // Handshake and status decode straight from the state register, so they are
  // glitch-free and o_load_done is exactly the single DONE cycle.
  assign o_ready     = (state == LOAD);
  assign o_busy      = (state != IDLE);
  assign o_load_done = (state == DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      o_ops      <= '0;
      o_beat_cnt <= '0;
    end else if (i_abort) begin
      // Abort wins over start and any beat presented in the same cycle.
      state      <= IDLE;
      o_ops      <= '0;
      o_beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= LOAD;
            o_ops      <= '0;
            o_beat_cnt <= '0;
          end
        end
        LOAD: begin
          if (i_valid) begin
            for (int j = 0; j < N_OPS; j++) begin
              o_ops[j*OP_W + int'(o_beat_cnt)*CHUNK_W +: CHUNK_W] <= i_chunk[j*CHUNK_W +: CHUNK_W];
            end
            o_beat_cnt <= o_beat_cnt + CNT_W'(1);
            if (o_beat_cnt == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OPERAND_LOADER_UNLOAD_EN
  typedef enum logic {U_IDLE, U_SEND} ustate_t;
  ustate_t         ustate;
  logic [OP_W-1:0]  ushift;
  logic [CNT_W-1:0] ucnt;

  // The shift register drains to zero as chunks leave, so the chunk output
  // reads 0 again once the word has been sent.
  assign o_unload_valid = (ustate == U_SEND);
  assign o_unload_chunk = ushift[CHUNK_W-1:0];
  assign o_unload_last  = (ustate == U_SEND) && (ucnt == LAST_BEAT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ustate <= U_IDLE;
      ushift <= '0;
      ucnt   <= '0;
    end else begin
      case (ustate)
        U_IDLE: begin
          if (i_unload_start) begin
            ustate <= U_SEND;
            ushift <= i_unload_word;
            ucnt   <= '0;
          end
        end
        U_SEND: begin
          if (i_unload_ready) begin
            ushift <= ushift >> CHUNK_W;
            ucnt   <= ucnt + CNT_W'(1);
            if (ucnt == LAST_BEAT) begin
              ustate <= U_IDLE;
            end
          end
        end
        default: ustate <= U_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_operand_loader_p.sv
// tb/tb_operand_loader_p.sv - directed self-checking bench for operand_loader_p
module tb_operand_loader_p;

  localparam int OP_W    = 32;
  localparam int CHUNK_W = 4;
  localparam int N_OPS   = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     valid = 1'b0;
  logic [N_OPS*CHUNK_W-1:0] chunk = '0;
  logic                     ready;
  logic                     busy;
  logic                     load_done;
  logic [N_OPS*OP_W-1:0]    ops;
  logic [3:0]               beat_cnt;
`ifdef OPERAND_LOADER_UNLOAD_EN
  logic                     u_start = 1'b0;
  logic [OP_W-1:0]          u_word = '0;
  logic [CHUNK_W-1:0]       u_chunk;
  logic                     u_valid;
  logic                     u_last;
  logic                     u_ready = 1'b0;
`endif

  int tests  = 0;
  int failed = 0;
  int pulses = 0;

  operand_loader_p #(.OP_W(OP_W), .CHUNK_W(CHUNK_W), .N_OPS(N_OPS)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_abort(abort),
    .i_valid(valid),
    .i_chunk(chunk),
    .o_ready(ready),
    .o_busy(busy),
    .o_load_done(load_done),
    .o_ops(ops),
    .o_beat_cnt(beat_cnt)
`ifdef OPERAND_LOADER_UNLOAD_EN
    ,
    .i_unload_start(u_start),
    .i_unload_word(u_word),
    .o_unload_chunk(u_chunk),
    .o_unload_valid(u_valid),
    .o_unload_last(u_last),
    .i_unload_ready(u_ready)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one beat and waits for the following sample point.
  task automatic beat(input logic [19:0] data);
    valid = 1'b1;
    chunk = data;
    tick();
    valid = 1'b0;
    if (load_done) pulses++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  localparam logic [159:0] OPS_A = {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h87654321};
  localparam logic [159:0] OPS_B = {128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 32'h12345678};

  initial begin
    // Reset state
    tick();
    chk("rst_ops", ops, '0);
    chk("rst_flags", {156'b0, ready, busy, load_done, 1'b0}, '0);
    chk("rst_cnt", beat_cnt, 0);
    rst = 1'b0;
    tick();

    // Back-to-back load, lane0 chunks 1..8, others 0xF
    do_start();
    chk("t1_ready_busy", {ready, busy}, 2'b11);
    chk("t1_cnt0", beat_cnt, 0);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      beat(20'hFFFF0 | 20'(n + 1));
      if (n < 7) chk("t1_no_early_done", load_done, 1'b0);
    end
    chk("t1_done", load_done, 1'b1);
    chk("t1_ready_in_done", ready, 1'b0);
    chk("t1_cnt8", beat_cnt, 8);
    chk("t1_ops", ops, OPS_A);
    tick();
    if (load_done) pulses++;
    tick();
    if (load_done) pulses++;
    chk("t1_single_pulse", pulses, 1);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_ops_hold", ops, OPS_A);

    // Stall of 3 cycles after beat 4
    do_start();
    chk("t2_cleared", ops, '0);
    for (int n = 0; n < 4; n++) beat(20'hFFFF0 | 20'(n + 1));
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t2_stall_cnt", beat_cnt, 4);
      chk("t2_stall_nodone", load_done, 1'b0);
    end
    for (int n = 4; n < 8; n++) begin
      chk("t2_not_yet_done", load_done, 1'b0);
      beat(20'hFFFF0 | 20'(n + 1));
    end
    chk("t2_done", load_done, 1'b1);
    chk("t2_ops", ops, OPS_A);
    tick();

    // Abort at beat count 5, beat in same cycle dropped
    do_start();
    for (int n = 0; n < 5; n++) beat(20'hFFFF0 | 20'(n + 1));
    chk("t3_cnt5", beat_cnt, 5);
    abort = 1'b1;
    valid = 1'b1;
    chunk = 20'hFFFF6;
    tick();
    abort = 1'b0;
    valid = 1'b0;
    chk("t3_ops_cleared", ops, '0);
    chk("t3_cnt_cleared", beat_cnt, 0);
    chk("t3_flags", {ready, busy, load_done}, 3'b000);
    tick();
    chk("t3_no_done", load_done, 1'b0);
    do_start();
    for (int n = 0; n < 8; n++) beat(20'hAAAA0 | 20'(8 - n));
    chk("t3_fresh_done", load_done, 1'b1);
    chk("t3_fresh_ops", ops, OPS_B);
    tick();

    // i_valid in IDLE and i_start in LOAD are ignored
    valid = 1'b1;
    chunk = 20'h12345;
    tick();
    tick();
    chk("t4_idle_cnt", beat_cnt, 8);
    chk("t4_idle_ops", ops, OPS_B);
    chk("t4_idle_ready", ready, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b0;
    chk("t4_start_beat_dropped", beat_cnt, 0);
    for (int n = 0; n < 3; n++) beat(20'hFFFF0 | 20'(n + 1));
    start = 1'b1;
    beat(20'hFFFF4);
    start = 1'b0;
    chk("t4_start_in_load", beat_cnt, 4);
    chk("t4_still_load", ready, 1'b1);
    for (int n = 4; n < 8; n++) beat(20'hFFFF0 | 20'(n + 1));
    chk("t4_ops", ops, OPS_A);
    tick();

    // Asynchronous reset mid-load
    do_start();
    for (int n = 0; n < 3; n++) beat(20'hFFFF0 | 20'(n + 1));
    #2 rst = 1'b1;
    #1;
    chk("t5_async_ops", ops, '0);
    chk("t5_async_cnt", beat_cnt, 0);
    chk("t5_async_flags", {ready, busy, load_done}, 3'b000);
    tick();
    rst = 1'b0;
    tick();

`ifdef OPERAND_LOADER_UNLOAD_EN
    begin
      logic [3:0] exp_seq [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
      chk("u_rst", {u_valid, u_last, u_chunk}, '0);
      u_word  = 32'hDEADBEEF;
      u_start = 1'b1;
      u_ready = 1'b1;
      tick();
      u_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk("u_valid", u_valid, 1'b1);
        chk("u_chunk", u_chunk, exp_seq[i]);
        chk("u_last", u_last, (i == 7));
        if (i == 2) begin
          u_ready = 1'b0;
          tick();
          tick();
          chk("u_stall_chunk", u_chunk, 4'hE);
          chk("u_stall_valid", u_valid, 1'b1);
          u_ready = 1'b1;
        end
        tick();
      end
      chk("u_end_valid", u_valid, 1'b0);
      u_ready = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/operand_loader_p.md
Name: operand_loader_p

Overview:
- Parametrised chunk-serial operand loader for the ECC datapath front end.
- Accepts N_OPS operands in parallel, CHUNK_W bits per operand per beat, over OP_W/CHUNK_W accepted beats.
- Assembles each operand into an OP_W register and pulses o_load_done for the Control/GFAU stage.
- Adds a valid/ready handshake, abort, busy status and an optional result unload serializer.

Parameters:
- OP_W, 32, operand width in bits; must be an integer multiple of CHUNK_W.
- CHUNK_W, 4, bits per operand per beat.
- N_OPS, 5, number of operand lanes (default lane order: Px, Py, prime, a, k).
- BEATS, OP_W/CHUNK_W, derived localparam, not overridable; default 8.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  arm a new load.
- i_abort  in  1  cancel the load in progress.
- i_valid  in  1  i_chunk holds a beat.
- i_chunk  in  N_OPS*CHUNK_W  lane j occupies bits [j*CHUNK_W +: CHUNK_W].
- o_ready  out  1  a beat is accepted when i_valid && o_ready.
- o_busy  out  1  high in LOAD or DONE.
- o_load_done  out  1  one-cycle pulse; all operands valid.
- o_ops  out  N_OPS*OP_W  lane j operand at bits [j*OP_W +: OP_W].
- o_beat_cnt  out  $clog2(BEATS+1)  beats accepted in the current load.

Behaviour:
- Reset values: state IDLE; o_ops=0, o_beat_cnt=0, o_ready=0, o_busy=0, o_load_done=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - o_ready=0.
  - i_start=1 moves to LOAD next cycle, clears o_ops and o_beat_cnt.
  - i_valid is ignored in IDLE, including the i_start cycle.
- LOAD:
  - o_ready=1 (combinational from state).
  - Each accepted beat n (n = o_beat_cnt, 0..BEATS-1) writes lane j's chunk into operand j bits [n*CHUNK_W +: CHUNK_W], LSB chunk first. Other bits hold.
  - o_beat_cnt increments per accepted beat.
  - i_valid=0 stalls with no change; there is no timeout.
  - On acceptance of beat BEATS-1: go to DONE.
- DONE:
  - Lasts exactly 1 cycle; o_load_done=1 (registered, from state); o_ready=0.
  - Next state IDLE.
  - Latency: last beat accepted at edge T gives o_load_done high during the cycle after T. Minimum load is BEATS+2 cycles from the i_start cycle.
- o_ops holds its value after DONE until the next accepted i_start or i_abort.
- i_start while in LOAD or DONE: ignored.
- i_abort (any state, priority over i_start and i_valid): next state IDLE, o_ops cleared, o_beat_cnt cleared, no o_load_done. A beat presented in the same cycle is dropped.
- Reset mid-load: immediate return to reset values.
- BEATS=1 (CHUNK_W=OP_W): a single beat goes LOAD to DONE.
- Elaboration must fail (generate-time error) if OP_W % CHUNK_W != 0.

Optional Feature:
- Macro OPERAND_LOADER_UNLOAD_EN.
- Defined: adds the following ports:
  - i_unload_start  in  1
  - i_unload_word  in  OP_W
  - o_unload_chunk  out  CHUNK_W
  - o_unload_valid  out  1
  - o_unload_last  out  1
  - i_unload_ready  in  1
- Unload behaviour:
  - Separate FSM (U_IDLE, U_SEND).
  - i_unload_start in U_IDLE captures i_unload_word into a shift register.
  - Chunks are emitted LSB-first, one per cycle when i_unload_ready=1.
  - o_unload_last marks chunk BEATS-1.
  - i_unload_start during U_SEND is ignored. i_abort does not affect unload.
  - Reset values: all unload outputs 0.
- Undefined: the ports and logic are absent; the load path is identical either way.

Test Plan:
- Defaults, i_start, then 8 back-to-back beats with lane0 chunks 1,2,...,8 and other lanes 0xF → op0=0x87654321, op1..op4=0xFFFFFFFF; o_load_done pulses exactly once, one cycle after the 8th beat.
- i_valid deasserted for 3 cycles after beat 4 → o_beat_cnt holds at 4, final operands unchanged versus the no-stall run, o_load_done delayed by 3 cycles.
- i_abort at o_beat_cnt=5 → IDLE next cycle, o_ops=0, no o_load_done; a fresh load afterwards completes correctly.
- i_start pulsed during LOAD, and i_valid asserted in IDLE → both ignored; o_beat_cnt unaffected.
- i_rst asserted asynchronously mid-load → all outputs 0 immediately, without waiting for a clock edge.
- With OPERAND_LOADER_UNLOAD_EN, i_unload_word=0xDEADBEEF and i_unload_ready stalled on chunk 2 → o_unload_chunk sequence F,E,E,B,D,A,E,D; o_unload_last asserted with the final D.
